id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV32 core, directly downstream of the decode control block.

---
 rtl/id_ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 5-stage RV32 core. It sits directly after the
// decode control block, captures the decoded control bits, register-file
// operands, immediate and register indices, and presents them to EX one cycle
// later. It also detects load-use hazards, inserts bubbles for flush, hazard,
// idle and unsupported-opcode cases, and keeps a saturating bubble counter for
// performance debug.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   id_valid            ID holds a real instruction this cycle
//   id_opcode           inst[6:0] of the ID instruction
//   id_ctrl             {alusrc,mem2reg,regwr,memrd,memwr,branch,aluop1,aluop2}
//   id_rs1, id_rs2      source register indices
//   id_rd               destination register index
//   id_rd1, id_rd2      register-file read data
//   id_imm              sign-extended immediate
//   id_funct            {inst[30], inst[14:12]}
//   flush               branch taken in EX: kill the ID instruction
//   hold                downstream stall: freeze this register
//   ex_*                registered copies of the ID fields, presented to EX
//   stall_if            combinational: IF/ID and PC must hold this cycle
//   illegal             one-cycle pulse: unsupported opcode was dropped
//   bubble_cnt          saturating count of flush/hazard/illegal bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [6:0]        id_opcode,
   input  logic [7:0]        id_ctrl,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [3:0]        id_funct,
   input  logic              flush,
   input  logic              hold,
   output logic              ex_valid,
   output logic [7:0]        ex_ctrl,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [3:0]        ex_funct,
   output logic              stall_if,
   output logic              illegal,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Bit positions inside the control byte.
   localparam int CTRL_MEM2REG = 6;
   localparam int CTRL_MEMRD   = 4;

   // What the register does on the next edge, in priority order.
   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_FLUSH,
      ACT_HAZ,
      ACT_ILLEGAL,
      ACT_ISSUE,
      ACT_IDLE
   } action_e;

   action_e    action;
   logic       haz;
   logic       supported;
   logic       count_bubble;
   logic [7:0] ctrl_fixed;

   // Load-use hazard: the instruction in EX is a load whose result the ID
   // instruction needs. x0 is never a real dependency. A load's rs2 field holds
   // immediate bits, so it must not be compared.
   always_comb begin
      haz = ex_valid && ex_ctrl[CTRL_MEMRD] && id_valid && (ex_rd != '0) &&
            ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && (id_opcode != OP_LOAD)));
   end

   // A flush kills the stalled instruction anyway, and under hold nothing
   // moves, so the front end only has to stall in the plain hazard case.
   assign stall_if = haz && !flush && !hold;

   always_comb begin
      supported = (id_opcode == OP_R)     || (id_opcode == OP_LOAD) ||
                  (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
   end

   // Stores and branches never write back, so mem2reg is meaningless for them
   // and is cleared to keep the write-back mux select clean.
   always_comb begin
      ctrl_fixed = id_ctrl;
      if ((id_opcode == OP_STORE) || (id_opcode == OP_BRANCH)) begin
         ctrl_fixed[CTRL_MEM2REG] = 1'b0;
      end
   end

   // NOTE: every signal driven from always_comb gets a default before any
   // branch; a path that leaves it unassigned would infer a latch.
   always_comb begin
      action = ACT_IDLE;
      if (hold) begin
         action = ACT_HOLD;
      end else if (flush) begin
         action = ACT_FLUSH;
      end else if (haz) begin
         action = ACT_HAZ;
      end else if (id_valid && !supported) begin
         action = ACT_ILLEGAL;
      end else if (id_valid) begin
         action = ACT_ISSUE;
      end
   end

   // Idle bubbles (id_valid=0) are not counted; only lost issue slots are.
   assign count_bubble = (action == ACT_FLUSH) || (action == ACT_HAZ) ||
                         (action == ACT_ILLEGAL);

   // NOTE: state is updated only with non-blocking assignments so that every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_funct <= '0;
         illegal  <= 1'b0;
      end else begin
         case (action)
            ACT_HOLD: begin
               // All ex_* fields keep their value; only the pulse drops.
               illegal <= 1'b0;
            end
            ACT_ISSUE: begin
               ex_valid <= 1'b1;
               ex_ctrl  <= ctrl_fixed;
               ex_rs1   <= id_rs1;
               ex_rs2   <= id_rs2;
               ex_rd    <= id_rd;
               ex_rd1   <= id_rd1;
               ex_rd2   <= id_rd2;
               ex_imm   <= id_imm;
               ex_funct <= id_funct;
               illegal  <= 1'b0;
            end
            default: begin
               // Bubble: control must be zero so no regwr/memwr can leak into
               // later stages; datapath fields are zeroed as well.
               ex_valid <= 1'b0;
               ex_ctrl  <= '0;
               ex_rs1   <= '0;
               ex_rs2   <= '0;
               ex_rd    <= '0;
               ex_rd1   <= '0;
               ex_rd2   <= '0;
               ex_imm   <= '0;
               ex_funct <= '0;
               illegal  <= (action == ACT_ILLEGAL);
            end
         endcase
      end
   end

   // Saturating bubble counter: stops at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (count_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A table of per-cycle vectors drives the
// ID inputs; the expected EX-side record for each vector is built when it is
// driven, pushed to a scoreboard queue, and popped and compared after the
// clock edge. stall_if is checked combinationally before the edge. Hand-written
// sequences cover reset, counter saturation and reset during operation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   // Narrow counter so saturation is reachable in a few cycles.
   localparam int CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_L   = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_ILL = 7'b0010011;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              id_valid;
   logic [6:0]        id_opcode;
   logic [7:0]        id_ctrl;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0]   id_rd1, id_rd2, id_imm;
   logic [3:0]        id_funct;
   logic              flush, hold;
   logic              ex_valid;
   logic [7:0]        ex_ctrl;
   logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0]   ex_rd1, ex_rd2, ex_imm;
   logic [3:0]        ex_funct;
   logic              stall_if, illegal;
   logic [CNT_W-1:0]  bubble_cnt;

   id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_funct(id_funct),
      .flush(flush), .hold(hold),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_funct(ex_funct),
      .stall_if(stall_if), .illegal(illegal), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {K_CAP, K_BUB, K_HOLD} kind_e;

   typedef struct {
      logic              valid;
      logic [6:0]        op;
      logic [7:0]        ctrl;
      logic [REG_AW-1:0] rs1, rs2, rd;
      logic [XLEN-1:0]   rd1, rd2, imm;
      logic [3:0]        funct;
      logic              flush, hold;
      kind_e             kind;
      logic [7:0]        exp_ctrl;
      logic              exp_stall;
      logic              exp_ill;
      logic [CNT_W-1:0]  exp_cnt;
   } vec_t;

   typedef struct {
      logic              valid;
      logic [7:0]        ctrl;
      logic [REG_AW-1:0] rs1, rs2, rd;
      logic [XLEN-1:0]   rd1, rd2, imm;
      logic [3:0]        funct;
      logic              ill;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   exp_t sb[$];
   exp_t last_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mkv(
      input logic valid, input logic [6:0] op, input logic [7:0] ctrl,
      input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
      input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2, input logic [XLEN-1:0] imm,
      input logic [3:0] funct, input logic fl, input logic hd, input kind_e kind,
      input logic [7:0] exp_ctrl, input logic exp_stall, input logic exp_ill,
      input logic [CNT_W-1:0] exp_cnt);
      vec_t v;
      v.valid = valid; v.op = op; v.ctrl = ctrl;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.funct = funct;
      v.flush = fl; v.hold = hd; v.kind = kind; v.exp_ctrl = exp_ctrl;
      v.exp_stall = exp_stall; v.exp_ill = exp_ill; v.exp_cnt = exp_cnt;
      return v;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e.valid = 1'b0; e.ctrl = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
      e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.funct = '0; e.ill = 1'b0; e.cnt = '0;
      return e;
   endfunction

   task automatic compare_outputs(input string tag, input exp_t e);
      check({tag, ".ex_valid"},   64'(ex_valid),   64'(e.valid));
      check({tag, ".ex_ctrl"},    64'(ex_ctrl),    64'(e.ctrl));
      check({tag, ".ex_rs1"},     64'(ex_rs1),     64'(e.rs1));
      check({tag, ".ex_rs2"},     64'(ex_rs2),     64'(e.rs2));
      check({tag, ".ex_rd"},      64'(ex_rd),      64'(e.rd));
      check({tag, ".ex_rd1"},     64'(ex_rd1),     64'(e.rd1));
      check({tag, ".ex_rd2"},     64'(ex_rd2),     64'(e.rd2));
      check({tag, ".ex_imm"},     64'(ex_imm),     64'(e.imm));
      check({tag, ".ex_funct"},   64'(ex_funct),   64'(e.funct));
      check({tag, ".illegal"},    64'(illegal),    64'(e.ill));
      check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.cnt));
   endtask

   // Drive one vector for one cycle: stall_if before the edge, registered
   // outputs after it via the scoreboard.
   task automatic run_vec(input string tag, input vec_t v);
      exp_t e;
      @(negedge clk);
      id_valid = v.valid; id_opcode = v.op; id_ctrl = v.ctrl;
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
      id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm; id_funct = v.funct;
      flush = v.flush; hold = v.hold;
      #1;
      check({tag, ".stall_if"}, 64'(stall_if), 64'(v.exp_stall));
      case (v.kind)
         K_CAP: begin
            e.valid = 1'b1; e.ctrl = v.exp_ctrl;
            e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd;
            e.rd1 = v.rd1; e.rd2 = v.rd2; e.imm = v.imm; e.funct = v.funct;
         end
         K_HOLD:  e = last_exp;
         default: e = zero_exp();
      endcase
      e.ill = v.exp_ill;
      e.cnt = v.exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         compare_outputs(tag, e);
         last_exp = e;
      end
   endtask

   initial begin
      vec_t v;
      logic [CNT_W-1:0] cnt_model;

      // --- reset state ------------------------------------------------------
      rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_ctrl = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd1 = '0; id_rd2 = '0;
      id_imm = '0; id_funct = '0; flush = 1'b0; hold = 1'b0;
      last_exp = zero_exp();
      #7;
      compare_outputs("reset", zero_exp());
      check("reset.stall_if", 64'(stall_if), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // --- vector table -----------------------------------------------------
      //             valid op    ctrl   rs1 rs2 rd  rd1  rd2  imm            funct fl hd kind    ectrl  st il cnt
      vecs.push_back(mkv(1, OP_R, 8'h22, 1, 2, 3,  5,   7,   0,             4'h0, 0, 0, K_CAP,  8'h22, 0, 0, 0)); // add x3,x1,x2
      vecs.push_back(mkv(1, OP_L, 8'hF0, 1, 0, 5,  100, 11,  0,             4'h2, 0, 0, K_CAP,  8'hF0, 0, 0, 0)); // lw x5,0(x1)
      vecs.push_back(mkv(1, OP_R, 8'h22, 5, 2, 6,  33,  7,   0,             4'h0, 0, 0, K_BUB,  8'h00, 1, 0, 1)); // add x6,x5,x2: stall
      vecs.push_back(mkv(1, OP_R, 8'h22, 5, 2, 6,  33,  7,   0,             4'h0, 0, 0, K_CAP,  8'h22, 0, 0, 1)); // re-presented
      vecs.push_back(mkv(1, OP_L, 8'hF0, 1, 0, 0,  8,   9,   12,            4'h2, 0, 0, K_CAP,  8'hF0, 0, 0, 1)); // lw x0
      vecs.push_back(mkv(1, OP_R, 8'h22, 0, 2, 6,  0,   7,   0,             4'h0, 0, 0, K_CAP,  8'h22, 0, 0, 1)); // add x6,x0,x2
      vecs.push_back(mkv(1, OP_L, 8'hF0, 1, 0, 5,  40,  0,   4,             4'h2, 0, 0, K_CAP,  8'hF0, 0, 0, 1)); // lw x5
      vecs.push_back(mkv(1, OP_L, 8'hF0, 2, 5, 7,  41,  0,   5,             4'h2, 0, 0, K_CAP,  8'hF0, 0, 0, 1)); // lw x7: rs2 field ignored
      vecs.push_back(mkv(1, OP_R, 8'h22, 7, 1, 8,  1,   2,   0,             4'h0, 1, 0, K_BUB,  8'h00, 0, 0, 2)); // flush+haz
      vecs.push_back(mkv(1, OP_S, 8'hC8, 1, 3, 4,  50,  60,  8,             4'h2, 0, 0, K_CAP,  8'h88, 0, 0, 2)); // sw: mem2reg forced 0
      vecs.push_back(mkv(1, OP_B, 8'h45, 1, 2, 0,  70,  80,  32'hFFFF_FFF0,  4'h0, 0, 0, K_CAP,  8'h05, 0, 0, 2)); // beq: mem2reg forced 0
      vecs.push_back(mkv(1, OP_R, 8'h22, 1, 2, 9,  1,   1,   0,             4'h0, 0, 1, K_HOLD, 8'h00, 0, 0, 2)); // hold 1
      vecs.push_back(mkv(1, OP_R, 8'h22, 1, 2, 9,  1,   1,   0,             4'h0, 1, 1, K_HOLD, 8'h00, 0, 0, 2)); // hold 2 (+flush lost)
      vecs.push_back(mkv(0, OP_R, 8'h22, 1, 2, 9,  1,   1,   0,             4'h0, 0, 1, K_HOLD, 8'h00, 0, 0, 2)); // hold 3
      vecs.push_back(mkv(1, OP_ILL,8'h22,1, 0, 10, 3,   0,   1,             4'h0, 0, 0, K_BUB,  8'h00, 0, 1, 3)); // unsupported opcode
      vecs.push_back(mkv(0, OP_R, 8'h22, 1, 2, 3,  9,   9,   0,             4'h0, 0, 0, K_BUB,  8'h00, 0, 0, 3)); // idle: not counted
      vecs.push_back(mkv(1, OP_L, 8'hF0, 1, 0, 5,  42,  0,   0,             4'h2, 0, 0, K_CAP,  8'hF0, 0, 0, 3)); // lw x5
      vecs.push_back(mkv(1, OP_R, 8'h22, 5, 2, 6,  1,   2,   0,             4'h0, 0, 1, K_HOLD, 8'h00, 0, 0, 3)); // haz under hold
      vecs.push_back(mkv(1, OP_R, 8'h22, 3, 5, 6,  1,   2,   0,             4'h0, 0, 0, K_BUB,  8'h00, 1, 0, 4)); // haz via rs2
      vecs.push_back(mkv(1, OP_R, 8'h22, 3, 5, 6,  1,   2,   0,             4'h8, 0, 0, K_CAP,  8'h22, 0, 0, 4)); // re-presented

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

      // --- saturation of bubble_cnt ------------------------------------------
      cnt_model = 4;
      for (int k = 0; k < 13; k++) begin
         if (cnt_model != CNT_MAX) cnt_model = cnt_model + 1'b1;
         v = mkv(1, OP_R, 8'h22, 1, 2, 3, 0, 0, 0, 4'h0, 1, 0, K_BUB, 8'h00, 0, 0, cnt_model);
         run_vec($sformatf("sat%0d", k), v);
      end

      // --- reset in the middle of a cycle with ex_valid=1 ----------------------
      v = mkv(1, OP_R, 8'h22, 1, 2, 3, 5, 7, 9, 4'h1, 0, 0, K_CAP, 8'h22, 0, 0, CNT_MAX);
      run_vec("pre_reset", v);
      #2;
      rst_n = 1'b0;
      #1;
      compare_outputs("mid_reset", zero_exp());
      @(negedge clk);
      rst_n = 1'b1;
      last_exp = zero_exp();
      v = mkv(1, OP_L, 8'hF0, 4, 0, 9, 77, 0, 3, 4'h2, 0, 0, K_CAP, 8'hF0, 0, 0, 0);
      run_vec("post_reset", v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
